// File: rtl/neopx_frame_sequencer.sv
// Frame controller ahead of the NeoPixel AXI-Stream serializer: host-writable pixel RAM,
// global brightness scaling, LED-type byte ordering and start/auto-refresh frame streaming.
module neopx_frame_sequencer #(
    parameter int CLK_FREQ_HZ = 72_000_000,
    parameter int LED_TYPE    = 0,
    parameter int MAX_PIXELS  = 64,
    parameter int ADDR_W      = 6,
    parameter int REFRESH_HZ  = 100
) (
    input  logic              axis_aclk,
    input  logic              axis_reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W:0]   pixel_count,
    input  logic [7:0]        brightness,
    input  logic              start,
    input  logic              auto_en,
    output logic              busy,
    output logic              frame_done,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    localparam int REFRESH_RAW = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int REFRESH_CYC = (REFRESH_RAW < 1) ? 1 : REFRESH_RAW;
    localparam int TIMER_W     = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_PRESENT,
        ST_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [TIMER_W-1:0]  timer_reg, timer_next;
    logic                pending_reg, pending_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic [31:0]         tdata_reg, tdata_next;
    logic                tvalid_reg, tvalid_next;
    logic                tlast_reg, tlast_next;
    logic [ADDR_W-1:0]   idx_reg, idx_next;
    logic [ADDR_W:0]     count_reg, count_next;
    logic [7:0]          bright_reg, bright_next;

    logic [31:0]         pixel_mem [MAX_PIXELS];
    logic [31:0]         rd_data_reg;

    logic                timer_expire;
    logic [8:0]          scale_mult;
    logic [7:0]          scaled [4];
    logic [31:0]         formatted;

    // Read-first RAM: the read only happens in READ, so a same-cycle write to that
    // address is seen by the next frame, not this one.
    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            pixel_mem[wr_addr] <= wr_data;
        end
        if (state_reg == ST_READ) begin
            rd_data_reg <= pixel_mem[idx_reg];
        end
    end

    assign timer_expire = auto_en && (timer_reg == TIMER_W'(REFRESH_CYC - 1));
    assign scale_mult   = {1'b0, bright_reg} + 9'd1;

    // Channel order in the RAM word is B, G, R, W from the low byte up.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_scale
            logic [15:0] product;
            assign product    = 16'(rd_data_reg[gi*8 +: 8]) * 16'(scale_mult);
            assign scaled[gi] = 8'(product >> 8);
        end
    endgenerate

    assign formatted = {scaled[1], scaled[2], scaled[0], (LED_TYPE == 1) ? scaled[3] : 8'h00};

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        pending_next = pending_reg | start | timer_expire;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        tdata_next   = tdata_reg;
        tvalid_next  = tvalid_reg;
        tlast_next   = tlast_reg;
        idx_next     = idx_reg;
        count_next   = count_reg;
        bright_next  = bright_reg;

        if (!auto_en || timer_expire) begin
            timer_next = '0;
        end else begin
            timer_next = timer_reg + TIMER_W'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                if (pending_reg) begin
                    // A request arriving in the accept cycle stays queued.
                    pending_next = start | timer_expire;
                    if (pixel_count != '0) begin
                        count_next  = pixel_count;
                        bright_next = brightness;
                        idx_next    = '0;
                        busy_next   = 1'b1;
                        state_next  = ST_READ;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_READ: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                tdata_next  = formatted;
                tvalid_next = 1'b1;
                tlast_next  = ({1'b0, idx_reg} == count_reg - (ADDR_W+1)'(1));
                state_next  = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (m_axis_tready) begin
                    tvalid_next = 1'b0;
                    tlast_next  = 1'b0;
                    if (tlast_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg + ADDR_W'(1);
                        state_next = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            pending_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            tdata_reg   <= '0;
            tvalid_reg  <= 1'b0;
            tlast_reg   <= 1'b0;
            idx_reg     <= '0;
            count_reg   <= '0;
            bright_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            pending_reg <= pending_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            tdata_reg   <= tdata_next;
            tvalid_reg  <= tvalid_next;
            tlast_reg   <= tlast_next;
            idx_reg     <= idx_next;
            count_reg   <= count_next;
            bright_reg  <= bright_next;
        end
    end

    assign busy          = busy_reg;
    assign frame_done    = done_reg;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;

endmodule

// File: tb/tb_neopx_frame_sequencer.sv
// Bench for neopx_frame_sequencer: one WS2812 and one SK6812 instance share stimulus; a frame-level
// scoreboard predicts every accepted beat from a shadow RAM and the requested frame parameters.
module tb_neopx_frame_sequencer;

    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            axis_reset;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [31:0]     wr_data;
    logic [AW:0]     pixel_count;
    logic [7:0]      brightness;
    logic            start;
    logic            auto_en;
    logic            tready;
    logic            busy_s   [2];
    logic            done_s   [2];
    logic            tvalid_s [2];
    logic            tlast_s  [2];
    logic [31:0]     tdata_s  [2];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            neopx_frame_sequencer #(
                .CLK_FREQ_HZ(1000),
                .LED_TYPE   (gi),
                .MAX_PIXELS (8),
                .ADDR_W     (AW),
                .REFRESH_HZ (100)
            ) u_dut (
                .axis_aclk     (clk),
                .axis_reset    (axis_reset),
                .wr_en         (wr_en),
                .wr_addr       (wr_addr),
                .wr_data       (wr_data),
                .pixel_count   (pixel_count),
                .brightness    (brightness),
                .start         (start),
                .auto_en       (auto_en),
                .busy          (busy_s[gi]),
                .frame_done    (done_s[gi]),
                .m_axis_tdata  (tdata_s[gi]),
                .m_axis_tvalid (tvalid_s[gi]),
                .m_axis_tlast  (tlast_s[gi]),
                .m_axis_tready (tready)
            );
        end
    endgenerate

    typedef struct {
        int count;
        int bright;
    } frame_t;

    frame_t       frames [$];
    int           fidx [2], bidx [2], hs_cnt [2], done_cnt [2], busy_cnt [2];
    int           cyc, checks, passes, exp_done;
    bit           stall_prev [2];
    logic [31:0]  tdata_prev [2];
    logic         tlast_prev [2];
    logic [32:0]  log0 [$];
    logic [32:0]  log1 [$];
    int           hs_time [$];
    logic [31:0]  shadow [8];

    // Each channel scaled as c*(b+1)/256, then arranged G,R,B,(W or 0).
    function automatic logic [31:0] expect_px(logic [31:0] px, int bright, int led_type);
        int ch [4];
        for (int k = 0; k < 4; k++) begin
            ch[k] = (int'(px[k*8 +: 8]) * (bright + 1)) / 256;
        end
        return {ch[1][7:0], ch[2][7:0], ch[0][7:0], (led_type == 1) ? ch[3][7:0] : 8'h00};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic compare_outputs();
        frame_t f;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (busy_s[i] === 1'b1) busy_cnt[i]++;
            if (done_s[i] === 1'b1) done_cnt[i]++;
            if (stall_prev[i]) begin
                chk("hold_tvalid", tvalid_s[i], 1);
                chk("hold_tdata", tdata_s[i], tdata_prev[i]);
                chk("hold_tlast", tlast_s[i], tlast_prev[i]);
            end
            if (tvalid_s[i] === 1'b1 && tready === 1'b1) begin
                hs_cnt[i]++;
                if (i == 0) begin
                    hs_time.push_back(cyc);
                    log0.push_back({tlast_s[i], tdata_s[i]});
                end else begin
                    log1.push_back({tlast_s[i], tdata_s[i]});
                end
                while (fidx[i] < frames.size() && frames[fidx[i]].count == 0) fidx[i]++;
                if (fidx[i] >= frames.size()) begin
                    chk("unexpected_beat", tvalid_s[i], 0);
                end else begin
                    f = frames[fidx[i]];
                    chk((i == 0) ? "beat_data_ws2812" : "beat_data_sk6812", tdata_s[i],
                        expect_px(shadow[bidx[i]], f.bright, i));
                    chk("beat_tlast", tlast_s[i], (bidx[i] == f.count - 1));
                    bidx[i]++;
                    if (bidx[i] == f.count) begin
                        fidx[i]++;
                        bidx[i] = 0;
                    end
                end
            end
            stall_prev[i] = (tvalid_s[i] === 1'b1) && (tready === 1'b0) && (axis_reset === 1'b0);
            tdata_prev[i] = tdata_s[i];
            tlast_prev[i] = tlast_s[i];
            if (axis_reset === 1'b1) begin
                fidx[i] = frames.size();
                bidx[i] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        shadow[a] = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic queue_frame(input int count, input int bright, input bit completes);
        frame_t f;
        f.count  = count;
        f.bright = bright;
        frames.push_back(f);
        if (completes) exp_done++;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done_cnt[0] >= exp_done && done_cnt[1] >= exp_done) break;
            cycle();
        end
        chk("frames_done_ws2812", done_cnt[0], exp_done);
        chk("frames_done_sk6812", done_cnt[1], exp_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bb, lb, l1, hb, tb0;
        axis_reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pixel_count = '0; brightness = '0; start = 1'b0; auto_en = 1'b0; tready = 1'b1;
        repeat (3) cycle();
        chk("rst_tvalid", tvalid_s[0], 0);
        chk("rst_tdata", tdata_s[0], 0);
        chk("rst_tlast", tlast_s[0], 0);
        chk("rst_busy", busy_s[0], 0);
        chk("rst_done", done_s[0], 0);
        chk("rst_tvalid_sk", tvalid_s[1], 0);
        axis_reset = 1'b0;
        cycle();

        // Basic two-pixel frame
        write_px(0, 32'h0011_2233);
        write_px(1, 32'h0044_5566);
        pixel_count = 2; brightness = 255;
        bb = busy_cnt[0]; lb = log0.size();
        queue_frame(2, 255, 1);
        pulse_start();
        wait_done(40);
        chk("basic_beat0", log0[lb], {1'b0, 32'h2211_3300});
        chk("basic_beat1", log0[lb+1], {1'b1, 32'h5544_6600});
        chk("basic_busy_cycles", busy_cnt[0] - bb, 7);

        // Brightness scaling
        write_px(0, 32'h80FF_4001);
        pixel_count = 1; brightness = 127;
        l1 = log1.size(); lb = log0.size();
        queue_frame(1, 127, 1);
        pulse_start();
        wait_done(40);
        chk("scale127_sk6812", log1[l1], {1'b1, 32'h207F_0040});
        chk("scale127_ws2812", log0[lb], {1'b1, 32'h207F_0000});
        brightness = 0;
        l1 = log1.size();
        queue_frame(1, 0, 1);
        pulse_start();
        wait_done(40);
        chk("scale0_sk6812", log1[l1], {1'b1, 32'h0000_0000});

        // Backpressure
        pixel_count = 2; brightness = 255; tready = 1'b0;
        queue_frame(2, 255, 1);
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            if (tvalid_s[0] === 1'b1) break;
            cycle();
        end
        chk("bp_tvalid_up", tvalid_s[0], 1);
        hb = hs_cnt[0];
        repeat (20) cycle();
        chk("bp_no_accept", hs_cnt[0] - hb, 0);
        tready = 1'b1;
        cycle();
        tready = 1'b0;
        repeat (4) cycle();
        chk("bp_one_accept", hs_cnt[0] - hb, 1);
        tready = 1'b1;
        wait_done(40);

        // Mid-frame parameter changes only affect the next frame
        write_px(2, 32'h00A0_B0C0);
        pixel_count = 3; brightness = 255;
        hb = hs_cnt[0];
        queue_frame(3, 255, 1);
        pulse_start();
        repeat (4) cycle();
        pixel_count = 1; brightness = 0;
        wait_done(40);
        chk("midchange_beats", hs_cnt[0] - hb, 3);
        hb = hs_cnt[0]; lb = log0.size();
        queue_frame(1, 0, 1);
        pulse_start();
        wait_done(40);
        chk("newparams_beats", hs_cnt[0] - hb, 1);
        chk("newparams_data", log0[lb], {1'b1, 32'h0000_0000});

        // Queued requests: start mid-frame, then start together with timer expiry
        write_px(3, 32'h0102_0304);
        pixel_count = 4; brightness = 200;
        hb = hs_cnt[0]; tb0 = hs_time.size();
        queue_frame(4, 200, 1);
        queue_frame(4, 200, 1);
        auto_en = 1'b1;
        pulse_start();
        repeat (3) cycle();
        pulse_start();
        repeat (4) cycle();
        pulse_start();
        auto_en = 1'b0;
        wait_done(100);
        chk("queued_beats", hs_cnt[0] - hb, 8);
        chk("pixel_gap", hs_time[tb0+1] - hs_time[tb0], 3);
        chk("back_to_back_gap", hs_time[tb0+4] - hs_time[tb0+3], 5);

        // Zero-length frame: done pulse, no beats
        pixel_count = 0;
        hb = hs_cnt[0];
        queue_frame(0, 200, 1);
        pulse_start();
        wait_done(20);
        chk("zero_count_beats", hs_cnt[0] - hb, 0);

        // Auto refresh every 10 cycles
        pixel_count = 1; brightness = 255;
        hb = hs_cnt[0]; tb0 = hs_time.size();
        for (int k = 0; k < 5; k++) queue_frame(1, 255, 1);
        auto_en = 1'b1;
        repeat (50) cycle();
        auto_en = 1'b0;
        wait_done(30);
        chk("auto_beats", hs_cnt[0] - hb, 5);
        for (int k = 1; k < 5; k++) begin
            chk("auto_period", hs_time[tb0+k] - hs_time[tb0+k-1], 10);
        end
        hb = hs_cnt[0];
        repeat (50) cycle();
        chk("auto_off_no_beats", hs_cnt[0] - hb, 0);
        chk("auto_off_no_done", done_cnt[0], exp_done);

        // Reset during the second of four pixels
        pixel_count = 4; brightness = 255;
        hb = hs_cnt[0];
        queue_frame(4, 255, 0);
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            if (hs_cnt[0] > hb) break;
            cycle();
        end
        chk("rst_first_beat_seen", hs_cnt[0] - hb, 1);
        axis_reset = 1'b1;
        cycle();
        chk("midrst_tvalid", tvalid_s[0], 0);
        chk("midrst_busy", busy_s[0], 0);
        axis_reset = 1'b0;
        repeat (5) cycle();
        chk("midrst_no_done", done_cnt[0], exp_done);
        hb = hs_cnt[0]; lb = log0.size();
        queue_frame(4, 255, 1);
        pulse_start();
        wait_done(40);
        chk("rst_restart_beats", hs_cnt[0] - hb, 4);
        chk("rst_first_pixel", log0[lb], {1'b0, 32'h40FF_0100});

        repeat (3) cycle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
